int_return_sequencer: RTL

- CPU-side responder to the 3-level nested interrupt controller.
- Consumes the controller's accept pulse and serviced-interrupt id, saves the return PC on a nesting stack, and redirects fetch to the handler vector.
- On a decoded return instruction (eret), issues the interruptEnd pulse, waits for interruptReturned, then restores the saved PC.
- Sits between the controller and the PC/fetch stage.

---
 rtl/int_resp_pkg.sv | 35 +++
 rtl/int_pc_stack.sv | 64 ++++++
 rtl/int_return_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_resp_pkg.sv
// Shared definitions for the interrupt return sequencer.
// Contents:
//   seq_state_e     - sequencer FSM states
//   DEF_VEC_BASE    - default address of the vector for interrupt 0
//   DEF_VEC_STRIDE  - default byte distance between consecutive vectors
//   lowest_set_idx  - index of the lowest set bit of an interrupt id
package int_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTER     = 3'd1,
        ST_EXIT_REQ  = 3'd2,
        ST_EXIT_WAIT = 3'd3,
        ST_RESUME    = 3'd4
    } seq_state_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0040;

    // The id is nominally one-hot; if several bits are set the lowest one
    // is serviced. Ids are zero-extended to 32 bits by the caller.
    function automatic logic [4:0] lowest_set_idx(input logic [31:0] id);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (id[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_pc_stack.sv
// LIFO of saved return PCs, one entry per nesting level.
// Ports:
//   clock, resetN      - clock (rising edge), async active-low reset
//   push, push_data    - store push_data on top (ignored when full)
//   pop                - discard the top entry (ignored when empty)
//   top_data           - current top entry (zero when empty)
//   full, empty, count - occupancy status
module int_pc_stack
    import int_resp_pkg::*;
#(
    parameter int unsigned NUM_IRQ  = 3,
    parameter int unsigned PC_WIDTH = 32,
    localparam int unsigned CW = $clog2(NUM_IRQ + 1),
    localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] push_data,
    output logic [PC_WIDTH-1:0] top_data,
    output logic                full,
    output logic                empty,
    output logic [CW-1:0]       count
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_IRQ);

    logic [PC_WIDTH-1:0] mem_r [NUM_IRQ];
    logic [CW-1:0]       count_r;
    logic [IW-1:0]       top_idx_s;

    // Occupancy flags and top-of-stack read.
    always_comb begin
        full      = (count_r == CNT_FULL);
        empty     = (count_r == {CW{1'b0}});
        count     = count_r;
        top_idx_s = IW'(count_r - CNT_ONE);
        if (empty) begin
            top_data = {PC_WIDTH{1'b0}};
        end else begin
            top_data = mem_r[top_idx_s];
        end
    end

    // Storage and occupancy counter; push has priority if both are raised.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_r <= {CW{1'b0}};
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                mem_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[IW'(count_r)] <= push_data;
            count_r             <= count_r + CNT_ONE;
        end else if (pop && !empty) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/int_return_sequencer.sv
// CPU-side responder to the nested interrupt controller. On an accepted
// interrupt it saves the return PC and redirects fetch to the handler
// vector; on eret it handshakes interruptEnd/interruptReturned with the
// controller and then redirects back to the saved PC. An interrupt that
// arrives mid-sequence is parked in a one-entry pending register.
// Optional feature: define INT_RET_TIMEOUT_EN to bound the wait for
// interruptReturned to RET_TIMEOUT cycles after interruptEnd (error is set
// and the return proceeds anyway).
// Ports:
//   clock, resetN      - clock (rising edge), async active-low reset
//   interrupted        - accept pulse from the controller
//   interruptOut       - one-hot id of the accepted interrupt
//   interruptReturned  - controller acknowledge of interruptEnd
//   pcNext             - return address of the interrupted stream
//   eret               - return instruction decoded
//   interruptEnd       - end-of-handler pulse to the controller
//   redirect, pcTarget - load pcTarget into the PC
//   stall              - pipeline freeze while a sequence runs
//   depth              - current nesting level
//   error              - sticky fault flag
module int_return_sequencer
    import int_resp_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned NUM_IRQ     = 3,
    parameter logic [31:0] VEC_BASE    = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE  = DEF_VEC_STRIDE,
    parameter int unsigned RET_TIMEOUT = 16,
    localparam int unsigned DW = $clog2(NUM_IRQ + 1)
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                interrupted,
    input  logic [NUM_IRQ-1:0]  interruptOut,
    input  logic                interruptReturned,
    input  logic [PC_WIDTH-1:0] pcNext,
    input  logic                eret,
    output logic                interruptEnd,
    output logic                redirect,
    output logic [PC_WIDTH-1:0] pcTarget,
    output logic                stall,
    output logic [DW-1:0]       depth,
    output logic                error
);

    seq_state_e          state_r;
    logic [PC_WIDTH-1:0] ret_pc_r;
    logic                pend_valid_r;
    logic [NUM_IRQ-1:0]  pend_id_r;
    logic                redirect_r;
    logic [PC_WIDTH-1:0] pc_target_r;
    logic                stall_r;
    logic                int_end_r;
    logic                error_r;

    logic                idle_s, id_zero_s, irq_req_s, irq_bad_s, irq_full_s;
    logic                take_irq_s, eret_ok_s, eret_bad_s, resume_pend_s;
    logic                consume_s, cap_ok_s, pend_ovf_s, pend_hit_s;
    logic                exit_go_s, push_s, pop_s, err_set_s, timeout_s;
    logic [NUM_IRQ-1:0]  irq_id_s;
    logic [PC_WIDTH-1:0] push_data_s, top_s;
    logic                full_s, empty_s;

    function automatic logic [PC_WIDTH-1:0] vec_addr(input logic [NUM_IRQ-1:0] id);
        logic [4:0] idx;
        idx = lowest_set_idx(32'(id));
        return PC_WIDTH'(VEC_BASE) + PC_WIDTH'(idx) * PC_WIDTH'(VEC_STRIDE);
    endfunction

    int_pc_stack #(
        .NUM_IRQ  (NUM_IRQ),
        .PC_WIDTH (PC_WIDTH)
    ) u_stack (
        .clock     (clock),
        .resetN    (resetN),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .top_data  (top_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (depth)
    );

`ifdef INT_RET_TIMEOUT_EN
    localparam int unsigned TW = $clog2(RET_TIMEOUT + 1);
    logic [TW-1:0] to_cnt_r;

    // Cycles elapsed since interruptEnd: 1 in the first EXIT_WAIT cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_EXIT_REQ) begin
            to_cnt_r <= TW'(1'b1);
        end else if (state_r == ST_EXIT_WAIT) begin
            to_cnt_r <= to_cnt_r + TW'(1'b1);
        end else begin
            to_cnt_r <= {TW{1'b0}};
        end
    end

    assign timeout_s = (state_r == ST_EXIT_WAIT) && !interruptReturned &&
                       (to_cnt_r == TW'(RET_TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Decode of the current-cycle decisions shared by FSM, stack and flags.
    always_comb begin
        idle_s     = (state_r == ST_IDLE);
        id_zero_s  = (interruptOut == {NUM_IRQ{1'b0}});
        // A parked interrupt is serviced ahead of a fresh one or an eret.
        irq_req_s  = idle_s && (pend_valid_r || interrupted);
        irq_id_s   = pend_valid_r ? pend_id_r : interruptOut;
        irq_bad_s  = irq_req_s && !pend_valid_r && id_zero_s;
        irq_full_s = irq_req_s && !irq_bad_s && full_s;
        take_irq_s = irq_req_s && !irq_bad_s && !full_s;
        eret_ok_s  = idle_s && !irq_req_s && eret && !empty_s;
        eret_bad_s = idle_s && !irq_req_s && eret && empty_s;
        resume_pend_s = (state_r == ST_RESUME) && pend_valid_r;
        consume_s  = (irq_req_s && pend_valid_r) || resume_pend_s;
        // In IDLE a fresh interrupt is parked only when the slot is being drained.
        cap_ok_s   = interrupted && !id_zero_s && (!idle_s || pend_valid_r);
        pend_ovf_s = cap_ok_s && pend_valid_r && !consume_s;
        pend_hit_s = pend_valid_r || cap_ok_s;
        exit_go_s  = (state_r == ST_EXIT_WAIT) && (interruptReturned || timeout_s);
        push_s      = take_irq_s || resume_pend_s;
        push_data_s = resume_pend_s ? ret_pc_r : pcNext;
        pop_s       = eret_ok_s;
        err_set_s   = (interrupted && id_zero_s) || irq_full_s || eret_bad_s ||
                      pend_ovf_s || timeout_s;
    end

    // Sequencer FSM; outputs are registered for the state being entered.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ST_IDLE;
            ret_pc_r    <= {PC_WIDTH{1'b0}};
            redirect_r  <= 1'b0;
            pc_target_r <= {PC_WIDTH{1'b0}};
            stall_r     <= 1'b0;
            int_end_r   <= 1'b0;
        end else begin
            redirect_r <= 1'b0;
            int_end_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (take_irq_s) begin
                        state_r     <= ST_ENTER;
                        redirect_r  <= 1'b1;
                        pc_target_r <= vec_addr(irq_id_s);
                        stall_r     <= 1'b1;
                    end else if (eret_ok_s) begin
                        state_r   <= ST_EXIT_REQ;
                        ret_pc_r  <= top_s;
                        int_end_r <= 1'b1;
                        stall_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        stall_r <= 1'b0;
                    end
                end
                ST_ENTER: begin
                    state_r <= ST_IDLE;
                    stall_r <= 1'b0;
                end
                ST_EXIT_REQ: begin
                    state_r <= ST_EXIT_WAIT;
                    stall_r <= 1'b1;
                end
                ST_EXIT_WAIT: begin
                    stall_r <= 1'b1;
                    if (exit_go_s) begin
                        state_r <= ST_RESUME;
                        // A parked interrupt means retPc is re-saved, not jumped to.
                        if (!pend_hit_s) begin
                            redirect_r  <= 1'b1;
                            pc_target_r <= ret_pc_r;
                        end else begin
                            redirect_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_EXIT_WAIT;
                    end
                end
                ST_RESUME: begin
                    if (resume_pend_s) begin
                        state_r     <= ST_ENTER;
                        redirect_r  <= 1'b1;
                        pc_target_r <= vec_addr(pend_id_r);
                        stall_r     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        stall_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    stall_r <= 1'b0;
                end
            endcase
        end
    end

    // One-entry pending slot for interrupts arriving mid-sequence.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pend_valid_r <= 1'b0;
            pend_id_r    <= {NUM_IRQ{1'b0}};
        end else if (consume_s) begin
            pend_valid_r <= cap_ok_s;
            pend_id_r    <= cap_ok_s ? interruptOut : pend_id_r;
        end else if (cap_ok_s && !pend_valid_r) begin
            pend_valid_r <= 1'b1;
            pend_id_r    <= interruptOut;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    // Sticky fault flag.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r | err_set_s;
        end
    end

    assign interruptEnd = int_end_r;
    assign redirect     = redirect_r;
    assign pcTarget     = pc_target_r;
    assign stall        = stall_r;
    assign error        = error_r;

endmodule
